pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_mask.sv | 39 +++
 rtl/pipe_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipe_ctrl lane controller: FSM encoding,
// default depth and the highest-set-bit flush mask helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam int DEFAULT_STAGES = 4;
    localparam int MAX_STAGES     = 32;

    // Every bit at or below the highest set request bit is set.
    function automatic logic [MAX_STAGES-1:0] flushMask(input logic [MAX_STAGES-1:0] req);
        logic [MAX_STAGES-1:0] mask;
        logic                  acc;
        mask = '0;
        acc  = 1'b0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            acc     = acc | req[i];
            mask[i] = acc;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mask.sv
// Combinational stalled/squash mask generator for pipe_ctrl (prefix-OR of
// stall_req and flush_req from the oldest stage downwards).
module pipe_ctrl_mask
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic [STAGES-1:0] stall_req_i,
    input  logic [STAGES-1:0] flush_req_i,
    output logic [STAGES-1:0] stalled_o,
    output logic [STAGES-1:0] squash_o
);

    logic [MAX_STAGES-1:0] flushWide;
    logic [MAX_STAGES-1:0] flushReqWide;
    logic [STAGES-1:0]     stallEdgeKeep;
    logic                  acc;

    always_comb begin
        flushReqWide               = '0;
        flushReqWide[STAGES-1:0]   = flush_req_i;
        flushWide                  = flushMask(flushReqWide);

        stalled_o = '0;
        acc       = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc          = acc | stall_req_i[i];
            stalled_o[i] = acc;
        end

        // The oldest register never gets a stall bubble; only a flush clears it.
        stallEdgeKeep             = '1;
        stallEdgeKeep[STAGES-1]   = 1'b0;

        squash_o = flushWide[STAGES-1:0]
                 | (stalled_o & ~(stalled_o >> 1) & stallEdgeKeep);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Per-lane pipeline control: valid tracking, stall/flush enables, drain FSM.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = DEFAULT_STAGES
`ifdef PIPE_CTRL_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    input  logic              drain_req,
    input  logic              resume,
    output logic              drained,
    output logic [STAGES-1:0] en,
    output logic [STAGES-1:0] squash,
    output logic [STAGES-1:0] valid,
`ifdef PIPE_CTRL_PERF_EN
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_stall_cycles,
`endif
    output logic              stalled_any
);

    state_e            state_q, state_d;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] stalled;
    logic [STAGES-1:0] maskSquash;

    pipe_ctrl_mask #(.STAGES(STAGES)) u_mask (
        .stall_req_i (stall_req),
        .flush_req_i (flush_req),
        .stalled_o   (stalled),
        .squash_o    (maskSquash)
    );

    assign en          = ~stalled;
    assign squash      = reset ? '1 : maskSquash;
    assign stalled_any = stalled[0];
    assign in_ready    = en[0] & ~flush_req[0] & (state_q == RUN);
    assign drained     = (state_q == HALT);
    assign valid       = valid_q;

    // Squash wins over enable; enabled registers shift occupancy one stage older.
    always_comb begin
        valid_d = valid_q;
        if (maskSquash[0])
            valid_d[0] = 1'b0;
        else if (en[0])
            valid_d[0] = in_valid & in_ready;
        for (int i = 1; i < STAGES; i++) begin
            if (maskSquash[i])
                valid_d[i] = 1'b0;
            else if (en[i])
                valid_d[i] = valid_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN:   if ((valid_d == '0) && (stall_req == '0)) state_d = HALT;
            HALT:    if (resume) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_q;

    // Saturating count of cycles spent stalled while holding live work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_q <= '0;
        else if (perf_clr)
            perf_q <= '0;
        else if (stalled_any && (valid_q != '0) && (perf_q != '1))
            perf_q <= perf_q + PERF_W'(1);
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (STAGES = 4); covers the
// PIPE_CTRL_PERF_EN counter when that macro is defined.
module tb_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] stall_req;
    logic [3:0] flush_req;
    logic       drain_req;
    logic       resume;
    logic       drained;
    logic [3:0] en;
    logic [3:0] squash;
    logic [3:0] valid;
    logic       stalled_any;
`ifdef PIPE_CTRL_PERF_EN
    logic       perf_clr;
    logic [3:0] perf_stall_cycles;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    pipe_ctrl #(
        .STAGES(4)
`ifdef PIPE_CTRL_PERF_EN
        , .PERF_W(4)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .drain_req   (drain_req),
        .resume      (resume),
        .drained     (drained),
        .en          (en),
        .squash      (squash),
        .valid       (valid),
`ifdef PIPE_CTRL_PERF_EN
        .perf_clr          (perf_clr),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .stalled_any (stalled_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic iv, input logic [3:0] st, input logic [3:0] fl,
                                 input logic dr, input logic rs);
        in_valid  = iv;
        stall_req = st;
        flush_req = fl;
        drain_req = dr;
        resume    = rs;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
        perf_clr = 1'b0;
`endif
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("reset_valid",   32'(valid),   32'h0);
        checkOutput("reset_squash",  32'(squash),  32'hF);
        checkOutput("reset_drained", 32'(drained), 32'h0);

        step();
        reset = 1'b0;

        // Fill with continuous input.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("fill_en",     32'(en),       32'hF);
        checkOutput("fill_squash", 32'(squash),   32'h0);
        checkOutput("fill_ready",  32'(in_ready), 32'h1);
        step(); checkOutput("fill_v1", 32'(valid), 32'b0001);
        step(); checkOutput("fill_v2", 32'(valid), 32'b0011);
        step(); checkOutput("fill_v3", 32'(valid), 32'b0111);
        step(); checkOutput("fill_v4", 32'(valid), 32'b1111);

        // Stall at stage 2 for two cycles.
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0);
        checkOutput("stall_en",     32'(en),          32'b1000);
        checkOutput("stall_squash", 32'(squash),      32'b0100);
        checkOutput("stall_ready",  32'(in_ready),    32'h0);
        checkOutput("stall_any",    32'(stalled_any), 32'h1);
        step(); checkOutput("stall_v1", 32'(valid), 32'b1011);
        step(); checkOutput("stall_v2", 32'(valid), 32'b0011);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("unstall_ready", 32'(in_ready), 32'h1);
        step(); checkOutput("unstall_v1", 32'(valid), 32'b0111);
        step(); checkOutput("unstall_v2", 32'(valid), 32'b1111);

        // Flush beats stall.
        applyStimulus(1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0);
        checkOutput("flush_squash", 32'(squash),   32'b0011);
        checkOutput("flush_ready",  32'(in_ready), 32'h0);
        checkOutput("flush_en",     32'(en),       32'b1110);
        step(); checkOutput("flush_valid", 32'(valid), 32'b1100);

        applyStimulus(1'b1, 4'b0000, 4'b0101, 1'b0, 1'b0);
        checkOutput("multiflush_squash", 32'(squash), 32'b0111);
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0);
        checkOutput("flush0_ready",  32'(in_ready), 32'h0);
        checkOutput("flush0_squash", 32'(squash),   32'b0001);

        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(); checkOutput("refill_v1", 32'(valid), 32'b1001);
        step(); step(); step();
        checkOutput("refill_v4", 32'(valid), 32'b1111);

        // Drain a full pipe with input still offered.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("drain_ready",   32'(in_ready), 32'h0);
        checkOutput("drain_drained", 32'(drained),  32'h0);
        checkOutput("drain_v0",      32'(valid),    32'b1111);
        step(); checkOutput("drain_v1", 32'(valid), 32'b1110);
        step(); checkOutput("drain_v2", 32'(valid), 32'b1100);
        step(); checkOutput("drain_v3", 32'(valid), 32'b1000);
        checkOutput("drain_not_yet", 32'(drained), 32'h0);
        step(); checkOutput("drain_v4", 32'(valid), 32'b0000);
        checkOutput("halt_drained", 32'(drained), 32'h1);
        checkOutput("halt_ready",   32'(in_ready), 32'h0);

        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step(); checkOutput("halt_ignore_drain", 32'(drained), 32'h1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("resume_drained", 32'(drained),  32'h0);
        checkOutput("resume_ready",   32'(in_ready), 32'h1);
        checkOutput("resume_valid",   32'(valid),    32'b0000);

        // Drain an empty pipe.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("empty_drain_ready", 32'(in_ready), 32'h0);
        step(); checkOutput("empty_drain_halt", 32'(drained), 32'h1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("empty_resume", 32'(drained), 32'h0);

        // Asynchronous reset in the middle of a drain.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0); step();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0); step();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0); step();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0); step();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("pre_reset_valid", 32'(valid),    32'b1010);
        checkOutput("pre_reset_ready", 32'(in_ready), 32'h0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_valid",   32'(valid),    32'b0000);
        checkOutput("async_reset_drained", 32'(drained),  32'h0);
        checkOutput("async_reset_squash",  32'(squash),   32'hF);
        checkOutput("async_reset_ready",   32'(in_ready), 32'h1);
        #2;
        reset = 1'b0;

`ifdef PIPE_CTRL_PERF_EN
        // Saturating stall counter.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(); step(); step(); step();
        checkOutput("perf_start", 32'(perf_stall_cycles), 32'h0);
        applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        checkOutput("perf_sat", 32'(perf_stall_cycles), 32'hF);
        checkOutput("perf_hold_valid", 32'(valid), 32'b1111);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        checkOutput("perf_clr", 32'(perf_stall_cycles), 32'h0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
